// File: rtl/clk_rst_pkg.sv
// Shared constants, domain/PLL maps and sequencer state type for the clock/reset controller.
package clk_rst_pkg;

    localparam int unsigned NUM_DOMAINS = 5;
    localparam int unsigned NUM_PLL     = 3;
    localparam int unsigned REF_DIV_W   = 4;
    localparam int unsigned FB_DIV_W    = 12;
    localparam int unsigned DOM_IDX_W   = 3;
    localparam int unsigned PLL_IDX_W   = 2;

    localparam logic [DOM_IDX_W-1:0] DOM_E  = 3'd0;
    localparam logic [DOM_IDX_W-1:0] DOM_P  = 3'd1;
    localparam logic [DOM_IDX_W-1:0] DOM_CL = 3'd2;
    localparam logic [DOM_IDX_W-1:0] DOM_SL = 3'd3;
    localparam logic [DOM_IDX_W-1:0] DOM_PL = 3'd4;

    // PLL feeding each domain, indexed by domain
    localparam logic [PLL_IDX_W-1:0] DOM_PLL [NUM_DOMAINS] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2};

    // Bring-up order; teardown of a relock group is done all at once
    localparam logic [DOM_IDX_W-1:0] DOM_ORDER [NUM_DOMAINS] = '{DOM_SL, DOM_PL, DOM_CL, DOM_P, DOM_E};

    typedef enum logic [3:0] {
        BOOT_LOCK,
        EN_CLK,
        REL_RST,
        RUN,
        FAIL,
        Q_RST,
        Q_GATE,
        LOAD,
        R_LOCK
    } seq_state_e;

    // Domains that depend on any PLL in the given mask
    function automatic logic [NUM_DOMAINS-1:0] dom_of_pll(input logic [NUM_PLL-1:0] plls);
        logic [NUM_DOMAINS-1:0] doms;
        doms = '0;
        for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
            doms[DOM_IDX_W'(d)] = plls[DOM_PLL[DOM_IDX_W'(d)]];
        end
        return doms;
    endfunction

    // PLLs feeding any domain in the given mask
    function automatic logic [NUM_PLL-1:0] pll_of_dom(input logic [NUM_DOMAINS-1:0] doms);
        logic [NUM_PLL-1:0] plls;
        plls = '0;
        for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
            if (doms[DOM_IDX_W'(d)]) begin
                plls[DOM_PLL[DOM_IDX_W'(d)]] = 1'b1;
            end
        end
        return plls;
    endfunction

    // One-hot of the earliest domain (in bring-up order) still pending
    function automatic logic [NUM_DOMAINS-1:0] first_in_order(input logic [NUM_DOMAINS-1:0] pend);
        logic [NUM_DOMAINS-1:0] pick;
        pick = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (pend[DOM_ORDER[DOM_IDX_W'(i)]]) begin
                pick = '0;
                pick[DOM_ORDER[DOM_IDX_W'(i)]] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // Two back-to-back capture stages, cleared to 0 on reset
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_seq_ctrl.sv
// Clock/reset sequencer: boot lock wait, ordered domain bring-up, run-time PLL relock.
module clk_rst_seq_ctrl
    import clk_rst_pkg::*;
#(
    parameter int unsigned             GAP_CYCLES   = 16,
    parameter int unsigned             LOCK_TIMEOUT = 4096,
    parameter logic [REF_DIV_W-1:0]    DEF_REF_DIV  = 4'd1,
    parameter logic [FB_DIV_W-1:0]     DEF_FB_DIV   = 12'd40
) (
    input  logic                                clk_i,
    input  logic                                arst_ni,
    input  logic                                cfg_valid_i,
    output logic                                cfg_ready_o,
    input  logic [PLL_IDX_W-1:0]                cfg_pll_sel_i,
    input  logic [REF_DIV_W-1:0]                cfg_ref_div_i,
    input  logic [FB_DIV_W-1:0]                 cfg_fb_div_i,
    output logic [NUM_PLL-1:0][REF_DIV_W-1:0]   pll_ref_div_o,
    output logic [NUM_PLL-1:0][FB_DIV_W-1:0]    pll_fb_div_o,
    input  logic [NUM_PLL-1:0]                  pll_locked_i,
    output logic [NUM_DOMAINS-1:0]              clk_en_o,
    output logic [NUM_DOMAINS-1:0]              arst_n_o,
    output logic                                busy_o,
    output logic                                err_o,
    output logic [NUM_PLL-1:0]                  err_pll_o
);

    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > GAP_CYCLES) ? LOCK_TIMEOUT : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_e                 state;
    logic [CNT_W-1:0]           cnt;
    logic [NUM_PLL-1:0]         pll_mask_q;
    logic [PLL_IDX_W-1:0]       sel_q;
    logic [REF_DIV_W-1:0]       new_ref_q;
    logic [FB_DIV_W-1:0]        new_fb_q;

    logic [NUM_PLL-1:0]         lock_s;
    logic [NUM_PLL-1:0]         req_mask;
    logic [NUM_PLL-1:0]         lost_pll;
    logic [NUM_DOMAINS-1:0]     dom_tgt;
    logic [NUM_DOMAINS-1:0]     req_dom;
    logic [NUM_DOMAINS-1:0]     en_pend;
    logic [NUM_DOMAINS-1:0]     rst_pend;
    logic [NUM_DOMAINS-1:0]     en_pick;
    logic [NUM_DOMAINS-1:0]     rst_pick;
    logic [NUM_DOMAINS-1:0]     lost_dom;
    logic                       gap_done;
    logic                       lock_tmo;

    for (genvar p = 0; p < NUM_PLL; p++) begin : g_lock_sync
        sync_2ff u_sync (
            .clk_i   (clk_i),
            .arst_ni (arst_ni),
            .d_i     (pll_locked_i[p]),
            .q_o     (lock_s[p])
        );
    end

    // Step selection, lock-loss detection and counter thresholds
    always_comb begin
        dom_tgt  = dom_of_pll(pll_mask_q);
        req_mask = NUM_PLL'(1) << cfg_pll_sel_i;
        req_dom  = dom_of_pll(req_mask);
        en_pend  = dom_tgt & ~clk_en_o;
        rst_pend = dom_tgt & ~arst_n_o;
        en_pick  = first_in_order(en_pend);
        rst_pick = first_in_order(rst_pend);
        lost_dom = arst_n_o & ~dom_of_pll(lock_s);
        lost_pll = pll_of_dom(lost_dom);
        gap_done = (cnt == CNT_W'(GAP_CYCLES - 1));
        lock_tmo = (cnt == CNT_W'(LOCK_TIMEOUT));
    end

    // Sequencer FSM with registered outputs; the shared counter restarts on every state change
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state         <= BOOT_LOCK;
            cnt           <= '0;
            pll_mask_q    <= '1;
            sel_q         <= '0;
            new_ref_q     <= DEF_REF_DIV;
            new_fb_q      <= DEF_FB_DIV;
            pll_ref_div_o <= {NUM_PLL{DEF_REF_DIV}};
            pll_fb_div_o  <= {NUM_PLL{DEF_FB_DIV}};
            clk_en_o      <= '0;
            arst_n_o      <= '0;
            cfg_ready_o   <= 1'b0;
            busy_o        <= 1'b1;
            err_o         <= 1'b0;
            err_pll_o     <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            unique case (state)
                BOOT_LOCK: begin
                    if (&lock_s) begin
                        state <= EN_CLK;
                        cnt   <= '0;
                    end else if (lock_tmo) begin
                        state     <= FAIL;
                        cnt       <= '0;
                        err_pll_o <= err_pll_o | ~lock_s;
                        err_o     <= 1'b1;
                        busy_o    <= 1'b0;
                    end
                end
                EN_CLK: begin
                    if (gap_done) begin
                        cnt      <= '0;
                        clk_en_o <= clk_en_o | en_pick;
                        if ((en_pend & ~en_pick) == '0) begin
                            state <= REL_RST;
                        end
                    end
                end
                REL_RST: begin
                    if (gap_done) begin
                        cnt      <= '0;
                        arst_n_o <= arst_n_o | rst_pick;
                        if ((rst_pend & ~rst_pick) == '0) begin
                            state       <= RUN;
                            busy_o      <= 1'b0;
                            cfg_ready_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt      <= '0;
                    arst_n_o <= arst_n_o & ~lost_dom;
                    if (|lost_pll) begin
                        err_pll_o <= err_pll_o | lost_pll;
                        err_o     <= 1'b1;
                    end
                    if (cfg_valid_i && (cfg_pll_sel_i != 2'd3)) begin
                        state       <= Q_RST;
                        sel_q       <= cfg_pll_sel_i;
                        pll_mask_q  <= req_mask;
                        new_ref_q   <= cfg_ref_div_i;
                        new_fb_q    <= cfg_fb_div_i;
                        arst_n_o    <= arst_n_o & ~lost_dom & ~req_dom;
                        cfg_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                FAIL: begin
                    cnt <= '0;
                end
                Q_RST: begin
                    if (gap_done) begin
                        state    <= Q_GATE;
                        cnt      <= '0;
                        clk_en_o <= clk_en_o & ~dom_tgt;
                    end
                end
                Q_GATE: begin
                    if (gap_done) begin
                        state                <= LOAD;
                        cnt                  <= '0;
                        pll_ref_div_o[sel_q] <= new_ref_q;
                        pll_fb_div_o[sel_q]  <= new_fb_q;
                    end
                end
                LOAD: begin
                    if (gap_done) begin
                        state <= R_LOCK;
                        cnt   <= '0;
                    end
                end
                R_LOCK: begin
                    if (|(lock_s & pll_mask_q)) begin
                        state     <= EN_CLK;
                        cnt       <= '0;
                        err_pll_o <= err_pll_o & ~pll_mask_q;
                    end else if (lock_tmo) begin
                        state       <= RUN;
                        cnt         <= '0;
                        err_pll_o   <= err_pll_o | pll_mask_q;
                        err_o       <= 1'b1;
                        busy_o      <= 1'b0;
                        cfg_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state <= FAIL;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_rst_seq_ctrl.sv
// Randomised self-checking bench for clk_rst_seq_ctrl against a timeline model of the sequencing rules.
module tb_clk_rst_seq_ctrl;

    localparam int unsigned G = 4;
    localparam int unsigned T = 64;

    logic              clk = 1'b0;
    logic              arst_n = 1'b1;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_sel;
    logic [3:0]        cfg_ref;
    logic [11:0]       cfg_fb;
    logic [2:0][3:0]   ref_div;
    logic [2:0][11:0]  fb_div;
    logic [2:0]        locked;
    logic [4:0]        clk_en;
    logic [4:0]        dom_rst_n;
    logic              busy;
    logic              err;
    logic [2:0]        err_pll;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference data: bring-up order and which PLL feeds each domain
    int ord    [5] = '{3, 4, 2, 1, 0};
    int pll_of [5] = '{0, 1, 2, 2, 2};

    // Model state
    logic [4:0]  m_en;
    logic [4:0]  m_rst;
    logic [2:0]  m_errp;
    logic        m_err;
    logic [3:0]  m_ref [3];
    logic [11:0] m_fb  [3];

    always #5 clk = ~clk;

    clk_rst_seq_ctrl #(
        .GAP_CYCLES   (G),
        .LOCK_TIMEOUT (T),
        .DEF_REF_DIV  (4'd1),
        .DEF_FB_DIV   (12'd40)
    ) dut (
        .clk_i         (clk),
        .arst_ni       (arst_n),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_pll_sel_i (cfg_sel),
        .cfg_ref_div_i (cfg_ref),
        .cfg_fb_div_i  (cfg_fb),
        .pll_ref_div_o (ref_div),
        .pll_fb_div_o  (fb_div),
        .pll_locked_i  (locked),
        .clk_en_o      (clk_en),
        .arst_n_o      (dom_rst_n),
        .busy_o        (busy),
        .err_o         (err),
        .err_pll_o     (err_pll)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] dm_of(input int p);
        logic [4:0] m;
        m = '0;
        for (int d = 0; d < 5; d++) if (pll_of[d] == p) m[d] = 1'b1;
        return m;
    endfunction

    // First k domains of mask dm, taken in bring-up order
    function automatic logic [4:0] prefix(input logic [4:0] dm, input int k);
        logic [4:0] r;
        int taken;
        r = '0;
        taken = 0;
        for (int i = 0; i < 5; i++) begin
            if (dm[ord[i]] && taken < k) begin
                r[ord[i]] = 1'b1;
                taken++;
            end
        end
        return r;
    endfunction

    task automatic chk_state(input string tag, input logic b, input logic r);
        chk({tag, ".clk_en"}, 32'(clk_en), 32'(m_en));
        chk({tag, ".arst_n"}, 32'(dom_rst_n), 32'(m_rst));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".ready"}, 32'(cfg_ready), 32'(r));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".err_pll"}, 32'(err_pll), 32'(m_errp));
    endtask

    task automatic chk_div(input string tag);
        for (int p = 0; p < 3; p++) begin
            chk({tag, ".ref_div"}, 32'(ref_div[p]), 32'(m_ref[p]));
            chk({tag, ".fb_div"}, 32'(fb_div[p]), 32'(m_fb[p]));
        end
    endtask

    // Assert reset (at any point in a cycle), check reset values, release just after an edge
    task automatic do_reset();
        arst_n = 1'b1;
        #1;
        arst_n = 1'b0;
        cfg_valid = 1'b0; cfg_sel = 2'd0; cfg_ref = 4'd0; cfg_fb = 12'd0;
        locked = 3'b000;
        m_en = '0; m_rst = '0; m_errp = '0; m_err = 1'b0;
        for (int p = 0; p < 3; p++) begin
            m_ref[p] = 4'd1;
            m_fb[p]  = 12'd40;
        end
        #1;
        chk_state("reset", 1'b1, 1'b0);
        chk_div("reset");
        tick();
        tick();
        arst_n = 1'b1;
    endtask

    // Ordered bring-up of the domains in dm; the step clock starts at the current edge
    task automatic run_seq(input logic [4:0] dm, input string tag);
        int n;
        logic [4:0] base_en;
        logic [4:0] base_rst;
        n = $countones(dm);
        base_en  = m_en & ~dm;
        base_rst = m_rst & ~dm;
        for (int e = 1; e <= 2 * n * int'(G); e++) begin
            int k;
            k = e / int'(G);
            tick();
            m_en  = base_en  | prefix(dm, (k < n) ? k : n);
            m_rst = base_rst | prefix(dm, (k > n) ? k - n : 0);
            chk_state(tag, k < 2 * n, k >= 2 * n);
        end
    endtask

    // Boot with all locks raised r cycles after reset release
    task automatic boot_ok(input int r);
        for (int i = 0; i < r; i++) begin
            tick();
            chk_state("boot_wait", 1'b1, 1'b0);
        end
        locked = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("boot_sync", 1'b1, 1'b0);
        end
        run_seq(5'b11111, "boot");
    endtask

    // Relock request; lock returns d cycles after the dividers load, or never
    task automatic relock(input logic [1:0] sel, input bit ok, input int d,
                          input logic [3:0] nref, input logic [11:0] nfb);
        logic [4:0] dm;
        int c_done;
        dm = dm_of(int'(sel));
        c_done = ok ? 2 * int'(G) + d + 3 : 3 * int'(G) + int'(T) + 1;
        cfg_valid = 1'b1; cfg_sel = sel; cfg_ref = nref; cfg_fb = nfb;
        tick();
        cfg_valid = 1'b0;
        locked[sel] = 1'b0;
        m_rst = m_rst & ~dm;
        chk_state("rq_accept", 1'b1, 1'b0);
        chk_div("rq_accept");
        for (int c = 1; c <= c_done; c++) begin
            tick();
            if (c == int'(G)) m_en = m_en & ~dm;
            if (c == 2 * int'(G)) begin
                m_ref[sel] = nref;
                m_fb[sel]  = nfb;
            end
            if (c == c_done) begin
                if (ok) m_errp[sel] = 1'b0;
                else begin
                    m_errp[sel] = 1'b1;
                    m_err = 1'b1;
                end
            end
            if (ok && c == 2 * int'(G) + d) locked[sel] = 1'b1;
            chk_state(ok ? "rq_lock" : "rq_tmo", !(c == c_done && !ok), (c == c_done && !ok));
            chk_div("rq");
        end
        if (ok) run_seq(dm, "restore");
    endtask

    // Lock drop in RUN; lock coming back on its own must not restore anything
    task automatic lock_loss(input logic [1:0] sel);
        logic [4:0] dm;
        dm = dm_of(int'(sel));
        locked[sel] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3 && (m_rst & dm) != '0) begin
                m_rst = m_rst & ~dm;
                m_errp[sel] = 1'b1;
                m_err = 1'b1;
            end
            chk_state("loss", 1'b0, 1'b1);
        end
        locked[sel] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_state("loss_hold", 1'b0, 1'b1);
        end
    endtask

    task automatic illegal_req();
        cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_ref = 4'($urandom); cfg_fb = 12'($urandom);
        tick();
        cfg_valid = 1'b0;
        for (int c = 0; c < 2 * int'(G); c++) begin
            chk_state("illegal", 1'b0, 1'b1);
            chk_div("illegal");
            tick();
        end
    endtask

    // Boot with a nonempty set of PLLs never locking
    task automatic boot_fail();
        logic [2:0] missing;
        int r;
        missing = 3'($urandom_range(1, 7));
        r = $urandom_range(1, 20);
        for (int e = 1; e <= int'(T) + 1; e++) begin
            tick();
            if (e == r) locked = ~missing;
            if (e == int'(T) + 1) begin
                m_errp = missing;
                m_err = 1'b1;
                chk_state("boot_fail", 1'b0, 1'b0);
            end else begin
                chk_state("boot_fail_wait", 1'b1, 1'b0);
            end
        end
        cfg_valid = 1'b1; cfg_sel = 2'($urandom_range(0, 2)); cfg_ref = 4'd9; cfg_fb = 12'd99;
        locked = 3'b111;
        for (int c = 0; c < 6 * int'(G); c++) begin
            tick();
            chk_state("fail_hold", 1'b0, 1'b0);
            chk_div("fail_hold");
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [1:0] s;
        int act;

        // Boot with locks at cycle 10, then the PLL1 relock from the plan
        do_reset();
        boot_ok(10);
        relock(2'd1, 1'b1, 20, 4'd2, 12'd50);

        // Lock loss on PLL0 then recovery
        lock_loss(2'd0);
        relock(2'd0, 1'b1, $urandom_range(G, 40), 4'($urandom), 12'($urandom));

        // PLL2 relock timeout, then a successful retry
        relock(2'd2, 1'b0, 0, 4'($urandom), 12'($urandom));
        illegal_req();
        relock(2'd2, 1'b1, $urandom_range(G, 40), 4'($urandom), 12'($urandom));

        // Random mix of run-time events
        for (int it = 0; it < 10; it++) begin
            act = $urandom_range(0, 4);
            s = 2'($urandom_range(0, 2));
            case (act)
                0, 1: relock(s, 1'b1, $urandom_range(G, 40), 4'($urandom), 12'($urandom));
                2: relock(s, 1'b0, 0, 4'($urandom), 12'($urandom));
                3: begin
                    if (locked[s]) lock_loss(s);
                    relock(s, 1'b1, $urandom_range(G, 40), 4'($urandom), 12'($urandom));
                end
                default: illegal_req();
            endcase
        end

        // Reset during LOAD of a PLL1 relock
        do_reset();
        boot_ok($urandom_range(1, 20));
        cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_ref = 4'd7; cfg_fb = 12'd77;
        tick();
        cfg_valid = 1'b0;
        locked[1] = 1'b0;
        m_rst = m_rst & ~dm_of(1);
        for (int c = 1; c <= 2 * int'(G) + 1; c++) begin
            tick();
            if (c == int'(G)) m_en = m_en & ~dm_of(1);
            if (c == 2 * int'(G)) begin
                m_ref[1] = 4'd7;
                m_fb[1]  = 12'd77;
            end
        end
        chk_state("abort_load", 1'b1, 1'b0);
        chk_div("abort_load");
        do_reset();

        // Boot that never locks
        boot_fail();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
